// File: rtl/div_fpu_seq.sv
// Sequential IEEE-754 single-precision divider. Restoring mantissa division, one
// quotient bit per clock, truncating rounding, denormal operands flushed to zero.
module div_fpu_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Result,
  output logic        NaN_error,
  output logic        div_by_zero,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;

  state_t            state_q, state_d;
  logic [25:0]       rem_q, rem_d;
  logic [24:0]       quo_q, quo_d;
  logic [23:0]       mb_q, mb_d;
  logic [4:0]        cnt_q, cnt_d;
  logic signed [9:0] exp_q, exp_d;
  logic              sign_q, sign_d;
  logic              special_q, special_d;
  logic [31:0]       sres_q, sres_d;
  logic              snan_q, snan_d;
  logic              sdbz_q, sdbz_d;
  logic [31:0]       result_q, result_d;
  logic              nan_q, nan_d;
  logic              dbz_q, dbz_d;
  logic              done_q, done_d;

  logic [7:0] a_exp, b_exp;
  logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, in_sign;
  assign a_exp   = A[30:23];
  assign b_exp   = B[30:23];
  assign a_zero  = (a_exp == 8'h00);
  assign b_zero  = (b_exp == 8'h00);
  assign a_inf   = (a_exp == 8'hFF) && (A[22:0] == 23'h0);
  assign b_inf   = (b_exp == 8'hFF) && (B[22:0] == 23'h0);
  assign a_nan   = (a_exp == 8'hFF) && (A[22:0] != 23'h0);
  assign b_nan   = (b_exp == 8'hFF) && (B[22:0] != 23'h0);
  assign in_sign = A[31] ^ B[31];

  // Special-operand result, resolved at the accept edge in priority order
  logic        in_special, in_nan, in_dbz;
  logic [31:0] in_sres;
  always_comb begin
    in_special = 1'b1;
    in_sres    = 32'h0000_0000;
    in_nan     = 1'b0;
    in_dbz     = 1'b0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      in_sres = 32'h7FC0_0000;
      in_nan  = 1'b1;
    end else if (b_zero) begin
      in_sres = {in_sign, 8'hFF, 23'h0};
      in_dbz  = 1'b1;
    end else if (a_inf) begin
      in_sres = {in_sign, 8'hFF, 23'h0};
    end else if (a_zero || b_inf) begin
      in_sres = {in_sign, 31'h0};
    end else begin
      in_special = 1'b0;
    end
  end

  // After a subtraction the remainder is below mB, so 25 bits hold it exactly
  logic        rem_ge;
  logic [24:0] rem_keep;
  assign rem_ge   = (rem_q >= {2'b00, mb_q});
  assign rem_keep = rem_ge ? (rem_q[24:0] - {1'b0, mb_q}) : rem_q[24:0];

  logic signed [9:0] exp_n;
  logic [22:0]       mant_n;
  logic [31:0]       norm_res;
  always_comb begin
    exp_n    = exp_q;
    mant_n   = quo_q[23:1];
    norm_res = 32'h0000_0000;
    if (!quo_q[24]) begin
      exp_n  = exp_q - 10'sd1;
      mant_n = quo_q[22:0];
    end
    if (exp_n >= 10'sd255)
      norm_res = {sign_q, 8'hFF, 23'h0};
    else if (exp_n <= 10'sd0)
      norm_res = {sign_q, 31'h0};
    else
      norm_res = {sign_q, exp_n[7:0], mant_n};
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    mb_d      = mb_q;
    cnt_d     = cnt_q;
    exp_d     = exp_q;
    sign_d    = sign_q;
    special_d = special_q;
    sres_d    = sres_q;
    snan_d    = snan_q;
    sdbz_d    = sdbz_q;
    result_d  = result_q;
    nan_d     = nan_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d    = in_sign;
          exp_d     = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + 10'sd127;
          rem_d     = {2'b01, A[22:0]};
          mb_d      = {1'b1, B[22:0]};
          quo_d     = 25'h0;
          cnt_d     = 5'd0;
          special_d = in_special;
          sres_d    = in_sres;
          snan_d    = in_nan;
          sdbz_d    = in_dbz;
          state_d   = in_special ? NORM : DIV;
        end
      end
      DIV: begin
        quo_d = {quo_q[23:0], rem_ge};
        rem_d = {rem_keep, 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd24) state_d = NORM;
      end
      NORM: begin
        if (special_q) begin
          result_d = sres_q;
          nan_d    = snan_q;
          dbz_d    = sdbz_q;
        end else begin
          result_d = norm_res;
          nan_d    = 1'b0;
          dbz_d    = 1'b0;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rem_q     <= 26'h0;
      quo_q     <= 25'h0;
      mb_q      <= 24'h0;
      cnt_q     <= 5'd0;
      exp_q     <= 10'sd0;
      sign_q    <= 1'b0;
      special_q <= 1'b0;
      sres_q    <= 32'h0;
      snan_q    <= 1'b0;
      sdbz_q    <= 1'b0;
      result_q  <= 32'h0;
      nan_q     <= 1'b0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      mb_q      <= mb_d;
      cnt_q     <= cnt_d;
      exp_q     <= exp_d;
      sign_q    <= sign_d;
      special_q <= special_d;
      sres_q    <= sres_d;
      snan_q    <= snan_d;
      sdbz_q    <= sdbz_d;
      result_q  <= result_d;
      nan_q     <= nan_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
    end
  end

  assign Result      = result_q;
  assign NaN_error   = nan_q;
  assign div_by_zero = dbz_q;
  assign done        = done_q;
  assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_div_fpu_seq.sv
// Randomised scoreboard bench for div_fpu_seq: expected results are queued by the
// driver from an arithmetic reference model and checked by a monitor on each done.
module tb_div_fpu_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] A = 32'h0;
  logic [31:0] B = 32'h0;
  logic [31:0] Result;
  logic        NaN_error, div_by_zero, busy, done;

  int vectors = 0;
  int miscompares = 0;
  logic [33:0] exp_q[$];
  logic [33:0] last_exp = 34'h0;

  div_fpu_seq dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .Result(Result), .NaN_error(NaN_error), .div_by_zero(div_by_zero),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference: {NaN_error, div_by_zero, Result} from the IEEE classification rules
  // and an exact integer quotient of the mantissas, truncated.
  function automatic logic [33:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    int unsigned ea, eb, fa, fb;
    logic s, az, bz, ai, bi, an, bn;
    longint unsigned q;
    int e;
    int unsigned mant;
    ea = a[30:23]; eb = b[30:23]; fa = a[22:0]; fb = b[22:0];
    s  = a[31] ^ b[31];
    az = (ea == 0); bz = (eb == 0);
    ai = (ea == 255) && (fa == 0); bi = (eb == 255) && (fb == 0);
    an = (ea == 255) && (fa != 0); bn = (eb == 255) && (fb != 0);
    if (an || bn || (az && bz) || (ai && bi)) return {2'b10, 32'h7FC00000};
    if (bz) return {2'b01, s, 8'hFF, 23'h0};
    if (ai) return {2'b00, s, 8'hFF, 23'h0};
    if (az || bi) return {2'b00, s, 31'h0};
    q = ((64'(fa) + 64'h800000) << 24) / (64'(fb) + 64'h800000);
    e = int'(ea) - int'(eb) + 127;
    if (q >= 64'h1000000) begin
      mant = int'((q >> 1) & 64'h7FFFFF);
    end else begin
      mant = int'(q & 64'h7FFFFF);
      e = e - 1;
    end
    if (e >= 255) return {2'b00, s, 8'hFF, 23'h0};
    if (e <= 0) return {2'b00, s, 31'h0};
    return {2'b00, s, e[7:0], mant[22:0]};
  endfunction

  function automatic logic is_special(input logic [31:0] a, input logic [31:0] b);
    return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) || (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
  endfunction

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", {NaN_error, div_by_zero, Result}, 34'h3FFFFFFFF);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("result", {NaN_error, div_by_zero, Result}, e);
        $display("done: Result=%h nan=%b dbz=%b expected=%h", Result, NaN_error, div_by_zero, e);
      end
    end
  end

  // Issue one request, then measure latency; optionally pulse start while busy
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit poke);
    int n;
    bit seen;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    last_exp = ref_div(a, b);
    exp_q.push_back(last_exp);
    $display("issue: A=%h B=%h", a, b);
    check("busy_after_accept", {33'h0, busy}, 34'h1);
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      if (poke && n == 5) begin
        A = $urandom; B = $urandom; start = 1'b1;
      end
      if (poke && n == 7) start = 1'b0;
      @(posedge clk);
      #1;
      n++;
      if (done) seen = 1;
    end
    check("latency", 34'(n), is_special(a, b) ? 34'd1 : 34'd26);
    A = a; B = b;
  endtask

  logic [31:0] ra, rb;
  initial begin
    rst = 1'b1; start = 1'b1; A = 32'h40C00000; B = 32'h40000000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {NaN_error, div_by_zero, Result}, 34'h0);
    check("reset_busy_done", {32'h0, busy, done}, 34'h0);
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_reset", {33'h0, busy}, 34'h0);

    issue(32'h40C00000, 32'h40000000, 0);
    issue(32'h3F800000, 32'h40400000, 0);
    issue(32'h7FC00001, 32'h3F800000, 0);
    issue(32'h00000000, 32'h80000000, 0);
    issue(32'hBF800000, 32'h00000000, 0);
    issue(32'h7F000000, 32'h00800000, 0);
    issue(32'h00800000, 32'h7F000000, 0);
    issue(32'hFF800000, 32'h7F800000, 0);
    issue(32'h7F800000, 32'hC0000000, 0);
    issue(32'h3F800000, 32'hFF800000, 0);

    // Abort a normal division part-way through
    @(negedge clk);
    A = 32'h40C00000; B = 32'h40000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_outputs", {NaN_error, div_by_zero, Result}, 34'h0);
    check("abort_busy_done", {32'h0, busy, done}, 34'h0);
    repeat (30) @(negedge clk);
    $display("abort: no done expected, busy=%b", busy);

    issue(32'h40C00000, 32'h40000000, 0);
    issue(32'h41200000, 32'h40400000, 1);
    repeat (3) @(negedge clk);
    check("result_hold", {NaN_error, div_by_zero, Result}, last_exp);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 7))
        0: ra[30:23] = 8'h00;
        1: rb[30:23] = 8'hFF;
        2: begin ra[30:23] = 8'(240 + $urandom_range(0, 14)); rb[30:23] = 8'(1 + $urandom_range(0, 10)); end
        3: begin ra[30:23] = 8'(1 + $urandom_range(0, 10)); rb[30:23] = 8'(240 + $urandom_range(0, 14)); end
        default: begin
          ra[30:23] = 8'(100 + $urandom_range(0, 50));
          rb[30:23] = 8'(100 + $urandom_range(0, 50));
        end
      endcase
      issue(ra, rb, (i % 8) == 3);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 34'(exp_q.size()), 34'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
